// File: rtl/forwarding_scoreboard_unit_if.sv
// Operand-forwarding / hazard bus between the IDEX stage and the forwarding scoreboard unit.
// The pipeline side is the master and the scoreboard unit is the slave.
interface forwarding_scoreboard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 4
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic [NUM_SRC*REG_W-1:0] in_src_rs;
  logic [NUM_SRC-1:0]       in_src_valid;
  logic [NUM_FWD*REG_W-1:0] in_fwd_rd;
  logic [NUM_FWD-1:0]       in_fwd_write_enable;
  logic [NUM_FWD-1:0]       in_fwd_data_ready;
  logic                     in_issue_valid;
  logic [REG_W-1:0]         in_issue_rd;
  logic [LAT_W-1:0]         in_issue_latency;
  logic                     in_flush;
  logic [NUM_SRC*SEL_W-1:0] out_forward_sel;
  logic                     out_stall;
  logic [REG_W:0]           out_pending_count;

  modport master (
    output in_src_rs, in_src_valid, in_fwd_rd, in_fwd_write_enable, in_fwd_data_ready,
           in_issue_valid, in_issue_rd, in_issue_latency, in_flush,
    input  out_forward_sel, out_stall, out_pending_count
  );

  modport slave (
    input  in_src_rs, in_src_valid, in_fwd_rd, in_fwd_write_enable, in_fwd_data_ready,
           in_issue_valid, in_issue_rd, in_issue_latency, in_flush,
    output out_forward_sel, out_stall, out_pending_count
  );
endinterface

// File: rtl/forwarding_scoreboard_unit.sv
// Forwarding select, load-use / RAW / WAW stall generation and a per-register
// countdown scoreboard for long-latency (mul/div) writes.
module forwarding_scoreboard_unit #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int REG_W   = 5,
  parameter int LAT_W   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  forwarding_scoreboard_unit_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int NREG  = 1 << REG_W;

  logic [NREG-1:0]            busy, busy_nxt;
  logic [NREG-1:0][LAT_W-1:0] cnt, cnt_nxt;
  logic [REG_W:0]             pending_q, pending_nxt;
  logic [NUM_SRC*SEL_W-1:0]   sel;
  logic                       load_use, raw, waw, stall, accept;

  // Forwarding scan: the lowest stage index (youngest) that matches wins.
  always_comb begin
    sel      = '0;
    load_use = 1'b0;
    raw      = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin : g_src
      logic [REG_W-1:0] rs;
      logic             matched;
      rs      = bus.in_src_rs[i*REG_W +: REG_W];
      matched = 1'b0;
      if (bus.in_src_valid[i]) begin
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
          if (!matched && bus.in_fwd_write_enable[k] &&
              bus.in_fwd_rd[k*REG_W +: REG_W] != '0 &&
              bus.in_fwd_rd[k*REG_W +: REG_W] == rs) begin
            matched                 = 1'b1;
            sel[i*SEL_W +: SEL_W]   = SEL_W'(k + 1);
            if (!bus.in_fwd_data_ready[k]) load_use = 1'b1;
          end
        end
        if (rs != '0 && busy[rs]) raw = 1'b1;
      end
    end
  end

  assign waw    = bus.in_issue_valid && bus.in_issue_rd != '0 && busy[bus.in_issue_rd];
  assign stall  = load_use | raw | waw;
  assign accept = bus.in_issue_valid && !bus.in_flush && !stall && bus.in_issue_rd != '0;

  // Expire/decrement first, then accept; a stalled issue is never accepted so
  // the accepted entry is never busy and the two updates cannot collide.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = cnt;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (busy[r]) begin
        if (cnt[r] > LAT_W'(1)) begin
          cnt_nxt[r] = cnt[r] - LAT_W'(1);
        end else begin
          busy_nxt[r] = 1'b0;
          cnt_nxt[r]  = '0;
        end
      end
    end
    if (accept) begin
      busy_nxt[bus.in_issue_rd] = 1'b1;
      cnt_nxt[bus.in_issue_rd]  = (bus.in_issue_latency == '0) ? LAT_W'(1) : bus.in_issue_latency;
    end
  end

  always_comb begin
    pending_nxt = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      pending_nxt = pending_nxt + {{REG_W{1'b0}}, busy_nxt[r]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy      <= '0;
      cnt       <= '0;
      pending_q <= '0;
    end else begin
      busy      <= busy_nxt;
      cnt       <= cnt_nxt;
      pending_q <= pending_nxt;
    end
  end

  assign bus.out_forward_sel   = sel;
  assign bus.out_stall         = stall;
  assign bus.out_pending_count = pending_q;
endmodule

// File: tb/tb_forwarding_scoreboard_unit.sv
// Directed and randomized checks of forwarding_scoreboard_unit against a
// register-level reference model that tracks remaining busy cycles per register.
module tb_forwarding_scoreboard_unit;
  localparam int NUM_SRC = 2;
  localparam int NUM_FWD = 2;
  localparam int REG_W   = 5;
  localparam int LAT_W   = 4;
  localparam int SEL_W   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  forwarding_scoreboard_unit_if #(.NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_W(REG_W), .LAT_W(LAT_W)) bus ();
  forwarding_scoreboard_unit #(.NUM_SRC(NUM_SRC), .NUM_FWD(NUM_FWD), .REG_W(REG_W), .LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // stimulus variables
  int rs[NUM_SRC], sv[NUM_SRC], frd[NUM_FWD], fwe[NUM_FWD], frdy[NUM_FWD];
  int iv, ird, ilat, fl;
  // model: remaining busy cycles per register (0 = free)
  int rem[32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NUM_SRC; i++) begin rs[i] = 0; sv[i] = 0; end
    for (int k = 0; k < NUM_FWD; k++) begin frd[k] = 0; fwe[k] = 0; frdy[k] = 1; end
    iv = 0; ird = 0; ilat = 0; fl = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.in_src_rs[i*REG_W +: REG_W] = REG_W'(rs[i]);
      bus.in_src_valid[i]             = sv[i][0];
    end
    for (int k = 0; k < NUM_FWD; k++) begin
      bus.in_fwd_rd[k*REG_W +: REG_W] = REG_W'(frd[k]);
      bus.in_fwd_write_enable[k]      = fwe[k][0];
      bus.in_fwd_data_ready[k]        = frdy[k][0];
    end
    bus.in_issue_valid   = iv[0];
    bus.in_issue_rd      = REG_W'(ird);
    bus.in_issue_latency = LAT_W'(ilat);
    bus.in_flush         = fl[0];
  endtask

  function automatic int m_sel(int i);
    if (sv[i] == 0) return 0;
    for (int k = 0; k < NUM_FWD; k++)
      if (fwe[k] != 0 && frd[k] != 0 && frd[k] == rs[i]) return k + 1;
    return 0;
  endfunction

  function automatic int m_stall();
    int s = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      int k = m_sel(i);
      if (k != 0 && frdy[k-1] == 0) s = 1;
      if (sv[i] != 0 && rs[i] != 0 && rem[rs[i]] > 0) s = 1;
    end
    if (iv != 0 && rem[ird] > 0) s = 1;
    return s;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) if (rem[r] > 0) c++;
    return c;
  endfunction

  // Compare against the model, clock once, advance the model, return at negedge.
  task automatic tick();
    int st;
    st = m_stall();
    for (int i = 0; i < NUM_SRC; i++)
      chk($sformatf("sel%0d", i), 32'(bus.out_forward_sel[i*SEL_W +: SEL_W]), 32'(m_sel(i)));
    chk("stall", 32'(bus.out_stall), 32'(st));
    chk("pending", 32'(bus.out_pending_count), 32'(m_count()));
    @(posedge clk);
    for (int r = 0; r < 32; r++) if (rem[r] > 0) rem[r]--;
    if (iv != 0 && fl == 0 && st == 0 && ird != 0) rem[ird] = (ilat == 0) ? 1 : ilat;
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rem[r] = 0;
    idle(); apply();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sel", 32'(bus.out_forward_sel), 32'd0);
    chk("rst_stall", 32'(bus.out_stall), 32'd0);
    chk("rst_count", 32'(bus.out_pending_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: youngest stage wins
    idle(); rs[0] = 5; rs[1] = 5; sv[0] = 1; sv[1] = 1;
    frd[0] = 5; frd[1] = 5; fwe[0] = 1; fwe[1] = 1; apply(); #1;
    chk("t1_sel", 32'(bus.out_forward_sel), 32'h5);
    chk("t1_stall", 32'(bus.out_stall), 32'd0);
    tick();

    // 2: x0 never forwards, older stage match
    idle(); rs[0] = 0; rs[1] = 3; sv[0] = 1; sv[1] = 1;
    frd[0] = 0; frd[1] = 3; fwe[0] = 1; fwe[1] = 1; apply(); #1;
    chk("t2_sel", 32'(bus.out_forward_sel), 32'h8);
    tick();

    // 3: load-use
    idle(); rs[0] = 7; sv[0] = 1; frd[0] = 7; fwe[0] = 1; frdy[0] = 0; apply(); #1;
    chk("t3_sel", 32'(bus.out_forward_sel), 32'h1);
    chk("t3_stall", 32'(bus.out_stall), 32'd1);
    tick();
    sv[0] = 0; apply(); #1;
    chk("t3_inv_stall", 32'(bus.out_stall), 32'd0);
    tick();

    // 4: long op rd=9 lat=3, then lat=0
    idle(); iv = 1; ird = 9; ilat = 3; apply(); #1; tick();
    for (int c = 1; c <= 4; c++) begin
      idle(); rs[0] = 9; sv[0] = 1; apply(); #1;
      chk($sformatf("t4_stall_c%0d", c), 32'(bus.out_stall), 32'(c <= 3));
      chk($sformatf("t4_count_c%0d", c), 32'(bus.out_pending_count), 32'(c <= 3));
      tick();
    end
    idle(); iv = 1; ird = 9; ilat = 0; apply(); #1; tick();
    idle(); rs[0] = 9; sv[0] = 1; apply(); #1;
    chk("t4_lat0_busy", 32'(bus.out_stall), 32'd1); tick();
    apply(); #1;
    chk("t4_lat0_free", 32'(bus.out_stall), 32'd0); tick();

    // 5: WAW hold and flush
    idle(); iv = 1; ird = 9; ilat = 4; apply(); #1; tick();
    idle(); iv = 1; ird = 9; ilat = 2; apply(); #1;
    chk("t5_waw_stall", 32'(bus.out_stall), 32'd1); tick();
    idle(); iv = 1; ird = 10; ilat = 2; fl = 1; apply(); #1;
    chk("t5_flush_stall", 32'(bus.out_stall), 32'd0); tick();
    idle(); apply(); #1;
    chk("t5_count", 32'(bus.out_pending_count), 32'd1); tick();
    repeat (4) tick();

    // 6: async reset mid-countdown (cnt[9] == 2)
    idle(); iv = 1; ird = 9; ilat = 3; apply(); #1; tick();
    idle(); apply(); #1; tick();
    rs[0] = 9; sv[0] = 1; apply(); #1;
    chk("t6_pre_stall", 32'(bus.out_stall), 32'd1);
    reset = 1'b0; #1;
    chk("t6_stall", 32'(bus.out_stall), 32'd0);
    chk("t6_count", 32'(bus.out_pending_count), 32'd0);
    for (int r = 0; r < 32; r++) rem[r] = 0;
    @(negedge clk);
    reset = 1'b1;

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rs[i] = $urandom_range(0, 3); sv[i] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      end
      for (int k = 0; k < NUM_FWD; k++) begin
        frd[k] = $urandom_range(0, 3); fwe[k] = $urandom_range(0, 1);
        frdy[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      end
      iv = ($urandom_range(0, 2) == 0) ? 1 : 0;
      ird = $urandom_range(0, 3); ilat = $urandom_range(0, 5);
      fl = ($urandom_range(0, 5) == 0) ? 1 : 0;
      apply(); #1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
